// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler.
// Requester IDs are carried at a fixed maximum width so one tag type serves every NUM_REQ up to MAX_REQ.
package mult_share_pkg;

  localparam int MAX_REQ_ID_W = 4;
  localparam int MAX_REQ      = 1 << MAX_REQ_ID_W;

  function automatic int req_id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                    vld;
    logic [MAX_REQ_ID_W-1:0] id;
  } mult_tag_t;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_REQ_ID_W-1:0] id);
    onehot     = '0;
    onehot[id] = 1'b1;
  endfunction

  function automatic logic [MAX_REQ_ID_W-1:0] encode(input logic [MAX_REQ-1:0] oh);
    encode = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) encode = MAX_REQ_ID_W'(i);
    end
  endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester, response and multiplier-side signals of the shared-multiplier scheduler.
// The scheduler uses the slave view; requesters, consumer and multiplier sit on the master view.
interface mult_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTHA  = 32,
  parameter int WIDTHB  = 32,
  parameter int WIDTHP  = 64
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WIDTHA-1:0] req_dataa;
  logic [NUM_REQ*WIDTHB-1:0] req_datab;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      resp_stall;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [WIDTHP-1:0]         resp_result;
  logic [WIDTHA-1:0]         mult_dataa;
  logic [WIDTHB-1:0]         mult_datab;
  logic                      mult_clken;
  logic                      mult_aclr;
  logic [WIDTHP-1:0]         mult_result;

  modport slave (
    input  req_valid, req_dataa, req_datab, resp_stall, mult_result,
    output req_grant, resp_valid, resp_result, mult_dataa, mult_datab, mult_clken, mult_aclr
  );

  modport master (
    output req_valid, req_dataa, req_datab, resp_stall, mult_result,
    input  req_grant, resp_valid, resp_result, mult_dataa, mult_datab, mult_clken, mult_aclr
  );

endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, ptr moves past the winner.
// Grant is combinational and suppressed while en is low.
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  localparam int ID_W = req_id_w(NUM_REQ);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic            hit;

  // Scan from farthest to nearest so the request closest to ptr is the last one written.
  always_comb begin
    hit = 1'b0;
    win = ptr;
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
    grant = '0;
    if (hit && en) grant[win] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (hit && en) begin
      ptr <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters: round-robin issue, requester ID
// carried alongside the multiplier pipeline, product routed back to its issuer.
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTHA       = 32,
  parameter int WIDTHB       = 32,
  parameter int WIDTHP       = 64,
  parameter int MULT_LATENCY = 1
) (
  input logic                clock,
  input logic                resetn,
  mult_share_sched_if.slave  bus
);

  logic               clken;
  logic [NUM_REQ-1:0] grant;
  logic [WIDTHA-1:0]  dataa;
  logic [WIDTHB-1:0]  datab;
  logic [NUM_REQ-1:0] resp_valid;
  mult_tag_t          tag_p [MULT_LATENCY];
  mult_tag_t          tag_last;

  assign clken          = ~bus.resp_stall & resetn;
  assign bus.mult_clken = clken;
  assign bus.mult_aclr  = ~resetn;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    (bus.req_valid),
    .en     (clken),
    .grant  (grant)
  );

  assign bus.req_grant = grant;

  // Issue: operands of the granted requester, zero on a bubble
  always_comb begin
    dataa = '0;
    datab = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        dataa = bus.req_dataa[i*WIDTHA +: WIDTHA];
        datab = bus.req_datab[i*WIDTHB +: WIDTHB];
      end
    end
  end

  assign bus.mult_dataa = dataa;
  assign bus.mult_datab = datab;

  // Tag stages p0..p(LAT-1) advance in lockstep with the multiplier so the last aligns with mult_result
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int s = 0; s < MULT_LATENCY; s++) tag_p[s].vld <= 1'b0;
    end else if (clken) begin
      tag_p[0].vld <= |grant;
      tag_p[0].id  <= encode(MAX_REQ'(grant));
      for (int s = 1; s < MULT_LATENCY; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  assign tag_last = tag_p[MULT_LATENCY-1];

  // Response decode
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = tag_last.vld && (tag_last.id == MAX_REQ_ID_W'(i));
    end
  end

  assign bus.resp_valid  = resp_valid;
  assign bus.resp_result = bus.mult_result;

endmodule
